einsum_add_pipe: RTL and testbench

//  Multi-lane, pipelined log-sum-exp (LSE) adder for the einsum PE datapath.
//  Per lane: sum = max(a,b) + LUT[|a-b| >> IDX_SHIFT].

---
 rtl/einsum_add_pipe.sv | 111 +++++++++++
 tb/tb_einsum_add_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/einsum_add_pipe.sv
// einsum_add_pipe: multi-lane two-stage log-sum-exp adder (max + LUT[|a-b|])
// with writable correction LUT, per-beat bypass and packet accumulation.
module einsum_add_pipe #(
    parameter int LANES         = 4,
    parameter int DATA_WIDTH    = 24,
    parameter int LUT_SIZE      = 1024,
    parameter int LUT_PRECISION = 10,
    parameter int IDX_SHIFT     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_bypass,
    input  logic                          in_acc,
    input  logic                          in_last,
    input  logic [LANES*DATA_WIDTH-1:0]   operand_a,
    input  logic [LANES*DATA_WIDTH-1:0]   operand_b,
    input  logic                          lut_we,
    input  logic [$clog2(LUT_SIZE)-1:0]   lut_addr,
    input  logic [LUT_PRECISION-1:0]      lut_wdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   sum_out,
    output logic                          out_last,
    output logic                          busy
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = $clog2(LUT_SIZE);
    localparam logic [DW:0] LUT_LIM = (DW+1)'(LUT_SIZE);

    logic [LUT_PRECISION-1:0] lut_q [LUT_SIZE];
    logic                     s1_vld_q, s1_byp_q, s1_accw_q, s1_last_q;
    logic                     s2_vld_q, s2_last_q, acc_open_q;
    logic [DW-1:0]            s1_max_q [LANES];
    logic [DW-1:0]            s1_idx_q [LANES];
    logic [DW-1:0]            s1_max_d [LANES];
    logic [DW-1:0]            s1_idx_d [LANES];
    logic [DW-1:0]            s2_sum_q [LANES];
    logic [DW-1:0]            s2_sum_d [LANES];
    logic [DW-1:0]            acc_q    [LANES];
    logic [DW-1:0]            op_a     [LANES];
    logic [DW-1:0]            op_b     [LANES];
    logic [DW-1:0]            corr     [LANES];
    logic [DW:0]              sum_w    [LANES];
    logic                     adv, acc_beat, accept;

    // A non-last accumulate beat sitting in S1 has not yet written acc, so the
    // next beat must wait until it moves on.
    assign adv      = !(s2_vld_q && !out_ready);
    assign in_ready = adv && !(s1_vld_q && s1_accw_q);
    assign acc_beat = in_acc && !in_bypass;
    assign accept   = in_valid && in_ready;
    assign out_valid = s2_vld_q;
    assign out_last  = s2_last_q;
    assign busy      = s1_vld_q || s2_vld_q || acc_open_q;

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign sum_out[g*DW +: DW] = s2_sum_q[g];
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            op_a[i]     = operand_a[i*DW +: DW];
            op_b[i]     = (acc_beat && acc_open_q) ? acc_q[i] : operand_b[i*DW +: DW];
            s1_max_d[i] = (in_bypass || op_a[i] >= op_b[i]) ? op_a[i] : op_b[i];
            s1_idx_d[i] = ((op_a[i] >= op_b[i]) ? op_a[i] - op_b[i] : op_b[i] - op_a[i]) >> IDX_SHIFT;
            corr[i]     = ({1'b0, s1_idx_q[i]} < LUT_LIM) ? DW'(lut_q[s1_idx_q[i][AW-1:0]]) : '0;
            sum_w[i]    = {1'b0, s1_max_q[i]} + {1'b0, corr[i]};
            s2_sum_d[i] = s1_byp_q ? s1_max_q[i] : (sum_w[i][DW] ? '1 : sum_w[i][DW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LUT_SIZE; i++) lut_q[i] <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_max_q[i] <= '0;
                s1_idx_q[i] <= '0;
                s2_sum_q[i] <= '0;
                acc_q[i]    <= '0;
            end
            s1_vld_q   <= 1'b0;
            s1_byp_q   <= 1'b0;
            s1_accw_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            acc_open_q <= 1'b0;
        end else begin
            if (lut_we) lut_q[lut_addr] <= lut_wdata;
            if (accept && acc_beat) acc_open_q <= !in_last;
            if (adv) begin
                s1_vld_q  <= accept;
                s1_byp_q  <= in_bypass;
                s1_accw_q <= accept && acc_beat && !in_last;
                s1_last_q <= in_last;
                s2_vld_q  <= s1_vld_q && !s1_accw_q;
                if (accept) begin
                    s1_max_q <= s1_max_d;
                    s1_idx_q <= s1_idx_d;
                end
                if (s1_vld_q && !s1_accw_q) begin
                    s2_sum_q  <= s2_sum_d;
                    s2_last_q <= s1_last_q;
                end
                if (s1_vld_q && s1_accw_q) acc_q <= s2_sum_d;
            end
        end
    end
endmodule

// File: tb/tb_einsum_add_pipe.sv
// tb_einsum_add_pipe: directed stimulus with queue scoreboard; a negedge
// monitor pops expected results whenever an output transfers.
module tb_einsum_add_pipe;
    localparam int LANES = 4;
    localparam int DW    = 24;
    localparam int W     = LANES*DW;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, in_bypass, in_acc, in_last;
    logic [W-1:0] operand_a, operand_b, sum_out;
    logic         lut_we, out_valid, out_ready, out_last, busy;
    logic [9:0]   lut_addr, lut_wdata;

    typedef struct {logic [W-1:0] sum; logic last;} exp_t;
    exp_t sb [$];
    int   checks = 0, failures = 0, out_cnt = 0;
    int   w;

    einsum_add_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_bypass(in_bypass), .in_acc(in_acc), .in_last(in_last),
        .operand_a(operand_a), .operand_b(operand_b), .lut_we(lut_we),
        .lut_addr(lut_addr), .lut_wdata(lut_wdata), .out_valid(out_valid),
        .out_ready(out_ready), .sum_out(sum_out), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rep(input logic [DW-1:0] x);
        return {LANES{x}};
    endfunction

    task automatic check(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    task automatic check1(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b", n, act, exp);
        end
    endtask

    task automatic checki(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", n, act, exp);
        end
    endtask

    task automatic lut_wr(input logic [9:0] addr, input logic [9:0] data);
        lut_we = 1'b1;
        lut_addr = addr;
        lut_wdata = data;
        @(posedge clk);
        #1 lut_we = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic byp,
                        input logic acc, input logic last, input logic exp_out,
                        input logic [W-1:0] exp, output int waited);
        in_valid = 1'b1;
        operand_a = a;
        operand_b = b;
        in_bypass = byp;
        in_acc = acc;
        in_last = last;
        waited = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 20) begin
                checks++;
                failures++;
                $display("FAIL send_timeout got=in_ready_low want=accept");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        if (exp_out) sb.push_back('{exp, last});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            out_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out got=%h want=none", sum_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum_out", sum_out, e.sum);
                check1("out_last", out_last, e.last);
            end
        end
    end

    initial begin
        int c0, wsum;
        rst = 1'b1; in_valid = 1'b0; in_bypass = 1'b0; in_acc = 1'b0; in_last = 1'b0;
        operand_a = '0; operand_b = '0; lut_we = 1'b0; lut_addr = '0; lut_wdata = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_sum_out", sum_out, '0);
        check1("rst_out_last", out_last, 1'b0);
        check1("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        check1("rst_in_ready", in_ready, 1'b1);

        // basic LSE, latency and full-throughput burst
        lut_wr(0, 5);
        lut_wr(3, 7);
        send(rep(100), rep(100), 0, 0, 1, 1, rep(105), w);
        @(negedge clk);
        check1("lat_cycle1", out_valid, 1'b0);
        @(negedge clk);
        check1("lat_cycle2", out_valid, 1'b1);
        @(posedge clk);
        #1 c0 = out_cnt;
        wsum = 0;
        send(rep(200), rep(200), 0, 0, 1, 1, rep(205), w); wsum += w;
        send({24'd7, 24'd0, 24'd40, 24'd100}, {24'd7, 24'd2000, 24'd43, 24'd100}, 0, 0, 1, 1,
             {24'd12, 24'd2000, 24'd50, 24'd105}, w); wsum += w;
        send(rep(24'hFFFFFF), rep(24'hFFFFFF), 0, 0, 0, 1, rep(24'hFFFFFF), w); wsum += w;
        send(rep(24'hFFFFFA), rep(24'hFFFFFA), 0, 0, 1, 1, rep(24'hFFFFFF), w); wsum += w;
        checki("burst_stalls", wsum, 0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 checki("burst_outputs", out_cnt - c0, 4);

        // LUT range edge, write/lookup collision, saturation edge
        lut_wr(1023, 3);
        send(rep(0), {24'd1024, 24'd1023, 24'd1024, 24'd1023}, 0, 0, 1, 1,
             {24'd1024, 24'd1026, 24'd1024, 24'd1026}, w);
        lut_wr(0, 1);
        send(rep(50), rep(50), 0, 0, 1, 1, rep(51), w);
        lut_wr(0, 9);
        send(rep(50), rep(50), 0, 0, 1, 1, rep(59), w);
        send({24'hFFFFF6, 24'hFFFFF7, 24'hFFFFF6, 24'hFFFFF7},
             {24'hFFFFF6, 24'hFFFFF7, 24'hFFFFF6, 24'hFFFFF7}, 0, 0, 1, 1, rep(24'hFFFFFF), w);

        // bypass
        send(rep(24'h123456), rep(0), 1, 0, 1, 1, rep(24'h123456), w);

        // accumulate packet with throttle
        lut_wr(0, 4);
        send(rep(10), rep(10), 0, 1, 0, 0, '0, w);
        checki("acc1_wait", w, 0);
        check1("acc1_throttle", in_ready, 1'b0);
        send(rep(14), rep(0), 0, 1, 0, 0, '0, w);
        checki("acc2_wait", w, 1);
        send(rep(18), rep(0), 0, 1, 1, 1, rep(22), w);
        checki("acc3_wait", w, 1);
        check1("acc_last_no_throttle", in_ready, 1'b1);

        // open packet interleaved with normal and bypass-acc beats
        send(rep(10), rep(10), 0, 1, 0, 0, '0, w);
        send(rep(30), rep(30), 0, 0, 1, 1, rep(34), w);
        checki("mix_normal_wait", w, 1);
        send(rep(77), rep(5), 1, 1, 0, 1, rep(77), w);
        checki("mix_bypass_wait", w, 0);
        send(rep(11), rep(0), 0, 1, 1, 1, rep(21), w);
        checki("mix_last_wait", w, 0);
        repeat (4) @(posedge clk);
        #1 check1("idle_busy", busy, 1'b0);

        // backpressure
        out_ready = 1'b0;
        fork
            begin
                send(rep(1), rep(1), 0, 0, 1, 1, rep(5), w);
                send(rep(2), rep(2), 0, 0, 1, 1, rep(6), w);
                send(rep(3), rep(3), 0, 0, 1, 1, rep(7), w);
            end
            begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check1("stall_valid", out_valid, 1'b1);
                    check("stall_sum", sum_out, rep(5));
                    check1("stall_in_ready", in_ready, 1'b0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // reset with beats in flight and an open packet
        send(rep(10), rep(10), 0, 1, 0, 0, '0, w);
        out_ready = 1'b0;
        send(rep(1), rep(1), 0, 0, 1, 1, rep(5), w);
        send(rep(2), rep(2), 0, 0, 1, 1, rep(6), w);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        check1("rst2_out_valid", out_valid, 1'b0);
        check1("rst2_busy", busy, 1'b0);
        check1("rst2_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        send({24'd5, 24'd0, 24'd40, 24'd100}, {24'd5, 24'd1023, 24'd43, 24'd100}, 0, 0, 1, 1,
             {24'd5, 24'd1023, 24'd43, 24'd100}, w);
        lut_wr(0, 4);
        send(rep(20), rep(20), 0, 1, 0, 0, '0, w);
        checki("fresh_first_wait", w, 0);
        send(rep(24), rep(0), 0, 1, 1, 1, rep(28), w);

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        #1 checki("drain_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
